// File: rtl/cnn_pkg.sv
// Shared types and sizing for the CNN accumulation datapath (MAC array -> feeder -> adder tree).
package cnn_pkg;

    localparam int ACC_WIDTH  = 32;
    localparam int TREE_DEPTH = 256;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    typedef logic signed [ACC_WIDTH-1:0] lane_t;

endpackage

// File: rtl/feeder_bank.sv
// One ping-pong bank of the adder-tree feeder: beat-addressed vector storage plus its
// EMPTY/FILLING/FULL occupancy state.
module feeder_bank
    import cnn_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int DEPTH = TREE_DEPTH,
    parameter int BEAT  = 16,
    localparam int NUM_BEATS = DEPTH / BEAT,
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [CNT_W-1:0]       wr_beat,
    input  logic                   wr_final,
    input  logic [BEAT*WIDTH-1:0]  wr_data,
    input  logic                   rd_done,
    output bank_state_t            state,
    output logic [DEPTH*WIDTH-1:0] data
);

    bank_state_t state_reg;
    bank_state_t state_next;

    // Storage is deliberately not reset; occupancy state alone says whether it is meaningful.
    logic [BEAT*WIDTH-1:0] mem_reg [NUM_BEATS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_beat] <= wr_data;
        end
    end

    // A bank is never written while FULL and never released unless FULL, so the two never collide.
    always_comb begin
        state_next = state_reg;
        if (rd_done) begin
            state_next = EMPTY;
        end
        if (wr_en) begin
            state_next = wr_final ? FULL : FILLING;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

    generate
        for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
            assign data[gi*BEAT*WIDTH +: BEAT*WIDTH] = mem_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/adder_tree_feeder_256.sv
// Deserialising ping-pong feeder: collects BEAT-lane beats into DEPTH-lane vectors and holds
// each completed vector stable for the adder tree until it is taken.
module adder_tree_feeder_256
    import cnn_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int DEPTH = TREE_DEPTH,
    parameter int BEAT  = 16,
    localparam int NUM_BEATS = DEPTH / BEAT,
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BEAT*WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DEPTH*WIDTH-1:0] vec_out,
    output logic                   err_len
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic             wr_bank_reg, wr_bank_next;
    logic             rd_bank_reg, rd_bank_next;
    logic             err_len_reg, err_len_next;

    bank_state_t            bank_state [2];
    logic [DEPTH*WIDTH-1:0] bank_data  [2];
    logic [1:0]             bank_wr_en;
    logic [1:0]             bank_rd_done;

    logic accept;
    logic out_fire;
    logic last_beat;

    // Ready depends only on bank occupancy (and reset), never on in_valid.
    assign in_ready  = rst_n && (bank_state[wr_bank_reg] != FULL);
    assign out_valid = (bank_state[rd_bank_reg] == FULL);
    assign vec_out   = bank_data[rd_bank_reg];
    assign err_len   = err_len_reg;

    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_beat = (beat_cnt_reg == LAST_BEAT);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_wr_en[gi]   = accept && (wr_bank_reg == 1'(gi));
            assign bank_rd_done[gi] = out_fire && (rd_bank_reg == 1'(gi));

            feeder_bank #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .BEAT  (BEAT)
            ) u_bank (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en    (bank_wr_en[gi]),
                .wr_beat  (beat_cnt_reg),
                .wr_final (last_beat),
                .wr_data  (in_data),
                .rd_done  (bank_rd_done[gi]),
                .state    (bank_state[gi]),
                .data     (bank_data[gi])
            );
        end
    endgenerate

    // Framing follows beat_cnt alone; in_last is only compared against it for the error flag.
    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        wr_bank_next  = wr_bank_reg;
        rd_bank_next  = rd_bank_reg ^ out_fire;
        err_len_next  = accept && (in_last != last_beat);
        if (accept) begin
            if (last_beat) begin
                beat_cnt_next = '0;
                wr_bank_next  = ~wr_bank_reg;
            end else begin
                beat_cnt_next = beat_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_reg <= '0;
            wr_bank_reg  <= 1'b0;
            rd_bank_reg  <= 1'b0;
            err_len_reg  <= 1'b0;
        end else begin
            beat_cnt_reg <= beat_cnt_next;
            wr_bank_reg  <= wr_bank_next;
            rd_bank_reg  <= rd_bank_next;
            err_len_reg  <= err_len_next;
        end
    end

endmodule

// File: tb/tb_adder_tree_feeder_256.sv
// Directed self-checking bench for adder_tree_feeder_256: reset, single vector, backpressure,
// streaming, framing errors and mid-vector reset.
module tb_adder_tree_feeder_256;

    localparam int W     = 32;
    localparam int DEPTH = 256;
    localparam int BEAT  = 16;
    localparam int NB    = DEPTH / BEAT;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [BEAT*W-1:0]    in_data = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [DEPTH*W-1:0]   vec_out;
    logic                 err_len;

    int total = 0;
    int bad   = 0;
    int stalls = 0;

    adder_tree_feeder_256 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vec_out   (vec_out),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BEAT*W-1:0] fill_beat(input int base, input int step);
        logic [BEAT*W-1:0] r;
        for (int j = 0; j < BEAT; j++) begin
            r[j*W +: W] = W'(base + step * j);
        end
        return r;
    endfunction

    function automatic longint tree_sum(input logic [DEPTH*W-1:0] v);
        longint s = 0;
        for (int i = 0; i < DEPTH; i++) begin
            s = s + longint'($signed(v[i*W +: W]));
        end
        return s;
    endfunction

    // Presents one beat and returns after the edge that accepts it (bounded wait).
    task automatic send_beat(input logic [BEAT*W-1:0] d, input logic last);
        bit rdy;
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        rdy = 1'b0;
        while (!rdy) begin
            rdy = in_ready;
            tick();
            if (!rdy) begin
                waited++;
                stalls++;
                if (waited > 50) begin
                    total++;
                    bad++;
                    $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", waited);
                    rdy = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = fill_beat(99, 1);
        repeat (3) tick();
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        total++;
        if (err_len !== 1'b0) begin bad++; $display("FAIL reset_err_len: got %b required 0", err_len); end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid: got %b required 0", out_valid); end
        $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_single_vector();
        logic [DEPTH*W-1:0] exp_vec;
        longint s;
        for (int i = 0; i < DEPTH; i++) exp_vec[i*W +: W] = W'(i);
        out_ready = 1'b0;
        for (int k = 0; k < NB - 1; k++) send_beat(fill_beat(k * BEAT, 1), 1'b0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b required 0", out_valid); end
        send_beat(fill_beat((NB - 1) * BEAT, 1), 1'b1);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b required 1", out_valid); end
        total++;
        if (vec_out !== exp_vec) begin
            bad++;
            for (int i = 0; i < DEPTH; i++) begin
                if (vec_out[i*W +: W] !== exp_vec[i*W +: W]) begin
                    $display("FAIL single_lanes: lane %0d got %0d required %0d", i, vec_out[i*W +: W], i);
                    break;
                end
            end
        end
        s = tree_sum(vec_out);
        total++;
        if (s != 64'sd32640) begin bad++; $display("FAIL single_sum: got %0d required 32640", s); end
        $display("single vector: sum=%0d", s);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: out_valid got %b required 0", out_valid); end
    endtask

    task automatic test_backpressure();
        longint s;
        out_ready = 1'b0;
        for (int v = 0; v < 2; v++)
            for (int k = 0; k < NB; k++) send_beat(fill_beat(-1, 0), k == NB - 1);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready: got %b required 0", in_ready); end
        in_valid = 1'b1;
        in_data  = fill_beat(-1, 0);
        in_last  = 1'b0;
        repeat (3) tick();
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_held_ready: got %b required 0", in_ready); end
        total++;
        if (vec_out !== {(DEPTH*W){1'b1}}) begin bad++; $display("FAIL bp_stable: lane0 got %0d required -1", $signed(vec_out[W-1:0])); end
        s = tree_sum(vec_out);
        total++;
        if (s != -64'sd256) begin bad++; $display("FAIL bp_sum: got %0d required -256", s); end
        $display("backpressure held vector: sum=%0d", s);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid: got %b required 1", out_valid); end
        // Third vector's final beat lands on the same edge the second vector is taken.
        for (int k = 0; k < NB - 1; k++) send_beat(fill_beat(-1, 0), 1'b0);
        out_ready = 1'b1;
        send_beat(fill_beat(-1, 0), 1'b1);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_simul_valid: got %b required 1", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_simul_ready: got %b required 1", in_ready); end
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: out_valid got %b required 0", out_valid); end
    endtask

    task automatic test_streaming();
        int t = 0;
        longint s;
        out_ready = 1'b1;
        stalls = 0;
        for (int v = 1; v <= 4; v++) begin
            for (int k = 0; k < NB; k++) begin
                send_beat(fill_beat(v, 0), k == NB - 1);
                t++;
                total++;
                if (out_valid !== ((t % NB) == 0)) begin
                    bad++;
                    $display("FAIL stream_valid: accept %0d out_valid got %b required %b", t, out_valid, (t % NB) == 0);
                end
                if ((t % NB) == 0) begin
                    s = tree_sum(vec_out);
                    total++;
                    if (s != longint'(256 * v)) begin bad++; $display("FAIL stream_sum: vector %0d got %0d required %0d", v, s, 256 * v); end
                    $display("stream vector %0d: sum=%0d", v, s);
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (stalls != 0) begin bad++; $display("FAIL stream_stalls: got %0d required 0", stalls); end
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: out_valid got %b required 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_framing();
        longint s;
        out_ready = 1'b1;
        for (int k = 0; k < NB; k++) begin
            send_beat(fill_beat(5, 0), k == 9);
            total++;
            if (err_len !== (k == 9 || k == NB - 1)) begin
                bad++;
                $display("FAIL frame_err: beat %0d err_len got %b required %b", k, err_len, (k == 9 || k == NB - 1));
            end
            if (k == 9) begin
                total++;
                if (out_valid !== 1'b0) begin bad++; $display("FAIL frame_truncate: out_valid got %b required 0", out_valid); end
            end
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL frame_complete: out_valid got %b required 1", out_valid); end
        s = tree_sum(vec_out);
        total++;
        if (s != 64'sd1280) begin bad++; $display("FAIL frame_sum: got %0d required 1280", s); end
        $display("framing vector: sum=%0d", s);
        tick();
        total++;
        if (err_len !== 1'b0) begin bad++; $display("FAIL frame_err_idle: got %b required 0", err_len); end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        int valid_seen = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 7; k++) send_beat(fill_beat(3, 0), 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mreset_valid: got %b required 0", out_valid); end
        for (int k = 0; k < NB; k++) begin
            send_beat(fill_beat(32'h7FFF_FFFF, 0), k == NB - 1);
            total++;
            if (err_len !== 1'b0) begin bad++; $display("FAIL mreset_err: beat %0d err_len got %b required 0", k, err_len); end
            if (k == NB - 2) begin
                total++;
                if (out_valid !== 1'b0) begin bad++; $display("FAIL mreset_early: out_valid got %b required 0", out_valid); end
            end
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL mreset_out: out_valid got %b required 1", out_valid); end
        total++;
        if (vec_out !== {DEPTH{32'h7FFF_FFFF}}) begin bad++; $display("FAIL mreset_lanes: lane0 got %h required 7fffffff", vec_out[W-1:0]); end
        $display("mid-reset vector: lane0=%h", vec_out[W-1:0]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) valid_seen++;
            tick();
        end
        total++;
        if (valid_seen != 0) begin bad++; $display("FAIL mreset_stale: extra out_valid cycles got %0d required 0", valid_seen); end
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_backpressure();
        test_streaming();
        test_framing();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
